// File: rtl/xenoa_audit_record_decoder.sv
// Buffers boundary-bound audit records, unpacks their fields and recovers the
// normalized value by dividing out the boundary-type scale factor.
module xenoa_audit_record_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int VAL_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [255:0]     in_audit_record,
    input  logic [VAL_W-1:0] in_bound_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_boundary_id,
    output logic [7:0]       out_boundary_type,
    output logic [31:0]      out_contract_id,
    output logic [31:0]      out_sla_id,
    output logic [63:0]      out_causal_id,
    output logic [31:0]      out_boundary_key,
    output logic [3:0]       out_severity,
    output logic [VAL_W-1:0] out_norm_value,
    output logic [2:0]       out_err,
    output logic [CNT_W-1:0] rec_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(VAL_W);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

    logic [255:0]     fifo_rec [FIFO_DEPTH];
    logic [VAL_W-1:0] fifo_val [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, empty;

    state_t           state;
    logic [255:0]     rec_q;
    logic [VAL_W-1:0] val_q, quo, quo_nx;
    logic [4:0]       rem, rem_nx, rem_shift;
    logic [3:0]       divisor;
    logic [DW-1:0]    div_cnt;
    logic             format_err, key_mismatch;

    assign empty    = (count == '0);
    assign in_ready = (count != (AW+1)'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = !empty && ((state == IDLE) || (state == OUT && out_ready));

    assign format_err   = (|rec_q[255:196]) || (|rec_q[7:0]);
    assign key_mismatch = (rec_q[43:28] != rec_q[195:180]);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rec[wr_ptr] <= in_audit_record;
            fifo_val[wr_ptr] <= in_bound_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One restoring-division step: remainder never exceeds 9, so 5 bits hold the shifted value.
    always_comb begin
        rem_shift = {rem[3:0], quo[VAL_W-1]};
        quo_nx    = {quo[VAL_W-2:0], 1'b0};
        rem_nx    = rem_shift;
        if (rem_shift >= {1'b0, divisor}) begin
            rem_nx    = rem_shift - {1'b0, divisor};
            quo_nx[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            rec_q             <= '0;
            val_q             <= '0;
            quo               <= '0;
            rem               <= '0;
            divisor           <= '0;
            div_cnt           <= '0;
            out_valid         <= 1'b0;
            out_boundary_id   <= '0;
            out_boundary_type <= '0;
            out_contract_id   <= '0;
            out_sla_id        <= '0;
            out_causal_id     <= '0;
            out_boundary_key  <= '0;
            out_severity      <= '0;
            out_norm_value    <= '0;
            out_err           <= '0;
            rec_count         <= '0;
            err_count         <= '0;
        end else begin
            if (pop) begin
                rec_q <= fifo_rec[rd_ptr];
                val_q <= fifo_val[rd_ptr];
            end
            case (state)
                IDLE: if (pop) state <= LOAD;
                LOAD: begin
                    out_boundary_id   <= rec_q[195:180];
                    out_boundary_type <= rec_q[179:172];
                    out_contract_id   <= rec_q[171:140];
                    out_sla_id        <= rec_q[139:108];
                    out_causal_id     <= rec_q[107:44];
                    out_boundary_key  <= rec_q[43:12];
                    out_severity      <= rec_q[11:8];
                    out_err[2:1]      <= {format_err, key_mismatch};
                    quo               <= val_q;
                    rem               <= '0;
                    div_cnt           <= DW'(VAL_W - 1);
                    case (rec_q[179:172])
                        8'd1: begin
                            out_norm_value <= val_q >> 1;
                            out_err[0]     <= val_q[0];
                            out_valid      <= 1'b1;
                            state          <= OUT;
                        end
                        8'd2: begin
                            divisor <= 4'd5;
                            state   <= DIV;
                        end
                        8'd3: begin
                            divisor <= 4'd10;
                            state   <= DIV;
                        end
                        default: begin
                            out_norm_value <= val_q;
                            out_err[0]     <= 1'b0;
                            out_valid      <= 1'b1;
                            state          <= OUT;
                        end
                    endcase
                end
                DIV: begin
                    quo     <= quo_nx;
                    rem     <= rem_nx;
                    div_cnt <= div_cnt - 1'b1;
                    if (div_cnt == '0) begin
                        out_norm_value <= quo_nx;
                        out_err[0]     <= (rem_nx != '0);
                        out_valid      <= 1'b1;
                        state          <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (rec_count != '1) rec_count <= rec_count + 1'b1;
                        if (out_err != '0 && err_count != '1) err_count <= err_count + 1'b1;
                        state <= pop ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xenoa_audit_record_decoder.sv
// Directed-vector bench for the audit record decoder; a second instance with
// 2-bit counters exercises counter saturation.
module tb_xenoa_audit_record_decoder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [255:0] in_audit_record = '0;
    logic [31:0]  in_bound_value = '0;

    logic         in_ready, out_valid;
    logic [15:0]  out_boundary_id;
    logic [7:0]   out_boundary_type;
    logic [31:0]  out_contract_id, out_sla_id, out_boundary_key, out_norm_value;
    logic [63:0]  out_causal_id;
    logic [3:0]   out_severity;
    logic [2:0]   out_err;
    logic [15:0]  rec_count, err_count;

    logic         s_in_ready, s_out_valid;
    logic [15:0]  s_boundary_id;
    logic [7:0]   s_boundary_type;
    logic [31:0]  s_contract_id, s_sla_id, s_boundary_key, s_norm_value;
    logic [63:0]  s_causal_id;
    logic [3:0]   s_severity;
    logic [2:0]   s_err;
    logic [1:0]   s_rec_count, s_err_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    always #5 clk = ~clk;

    xenoa_audit_record_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_audit_record(in_audit_record), .in_bound_value(in_bound_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_boundary_id(out_boundary_id), .out_boundary_type(out_boundary_type),
        .out_contract_id(out_contract_id), .out_sla_id(out_sla_id),
        .out_causal_id(out_causal_id), .out_boundary_key(out_boundary_key),
        .out_severity(out_severity), .out_norm_value(out_norm_value),
        .out_err(out_err), .rec_count(rec_count), .err_count(err_count)
    );

    xenoa_audit_record_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_audit_record(in_audit_record), .in_bound_value(in_bound_value),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_boundary_id(s_boundary_id), .out_boundary_type(s_boundary_type),
        .out_contract_id(s_contract_id), .out_sla_id(s_sla_id),
        .out_causal_id(s_causal_id), .out_boundary_key(s_boundary_key),
        .out_severity(s_severity), .out_norm_value(s_norm_value),
        .out_err(s_err), .rec_count(s_rec_count), .err_count(s_err_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [59:0] res_hi, input logic [15:0] id,
                                        input logic [7:0] btype, input logic [31:0] key,
                                        input logic [7:0] res_lo);
        return {res_hi, id, btype, 32'hC0C0_0001, 32'h5A5A_0002, 64'h0123_4567_89AB_CDEF,
                key, 4'h9, res_lo};
    endfunction

    task automatic push(input logic [255:0] rec, input logic [31:0] val);
        @(negedge clk);
        in_audit_record = rec;
        in_bound_value  = val;
        in_valid        = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_norm", out_norm_value, 0);
        chk("rst_rec_cnt", rec_count, 0);
        chk("rst_err_cnt", err_count, 0);

        push(mk(60'h0, 16'h00A5, 8'd0, 32'h00A5_1111, 8'h00), 32'h1234);
        wait_out(cyc);
        chk("t0_latency", cyc, 2);
        chk("t0_norm", out_norm_value, 32'h1234);
        chk("t0_err", out_err, 3'b000);
        chk("t0_id", out_boundary_id, 16'h00A5);
        chk("t0_type", out_boundary_type, 8'd0);
        chk("t0_contract", out_contract_id, 32'hC0C0_0001);
        chk("t0_sla", out_sla_id, 32'h5A5A_0002);
        chk("t0_causal", out_causal_id, 64'h0123_4567_89AB_CDEF);
        chk("t0_key", out_boundary_key, 32'h00A5_1111);
        chk("t0_sev", out_severity, 4'h9);
        repeat (3) @(posedge clk);
        #1 chk("t0_hold", out_norm_value, 32'h1234);
        consume();
        chk("t0_rec_cnt", rec_count, 1);

        push(mk(60'h0, 16'h0002, 8'd3, 32'h0002_0000, 8'h00), 32'd1000);
        wait_out(cyc);
        chk("t3_latency", cyc, 34);
        chk("t3_norm", out_norm_value, 32'd100);
        chk("t3_err", out_err, 3'b000);
        consume();
        push(mk(60'h0, 16'h0002, 8'd3, 32'h0002_0000, 8'h00), 32'd1003);
        wait_out(cyc);
        chk("t3r_norm", out_norm_value, 32'd100);
        chk("t3r_err", out_err, 3'b001);
        consume();

        push(mk(60'h0, 16'h0003, 8'd1, 32'h0003_0000, 8'h00), 32'd7);
        wait_out(cyc);
        chk("t1_latency", cyc, 2);
        chk("t1_norm", out_norm_value, 32'd3);
        chk("t1_err", out_err, 3'b001);
        consume();
        push(mk(60'h0, 16'h0004, 8'h7F, 32'h0004_0000, 8'h00), 32'd9);
        wait_out(cyc);
        chk("tu_norm", out_norm_value, 32'd9);
        chk("tu_err", out_err, 3'b000);
        consume();

        push(mk(60'h800000000000000, 16'h0001, 8'd0, 32'hBEEF_0000, 8'h00), 32'd5);
        wait_out(cyc);
        chk("fe_err", out_err, 3'b110);
        chk("fe_id", out_boundary_id, 16'h0001);
        chk("fe_norm", out_norm_value, 32'd5);
        consume();
        chk("fe_err_cnt", err_count, 3);
        push(mk(60'h0, 16'h0006, 8'd0, 32'h0006_0000, 8'h01), 32'd4);
        wait_out(cyc);
        chk("fl_err", out_err, 3'b100);
        consume();

        // backpressure: one record held in the FSM, four in the buffer
        push(mk(60'h0, 16'h0010, 8'd0, 32'h0010_0000, 8'h00), 32'd10);
        push(mk(60'h0, 16'h0011, 8'd0, 32'h0011_0000, 8'h00), 32'd11);
        push(mk(60'h0, 16'h0012, 8'd1, 32'h0012_0000, 8'h00), 32'd21);
        push(mk(60'h0, 16'h0013, 8'd0, 32'h0013_0000, 8'h00), 32'd13);
        chk("bp_ready_3", in_ready, 1);
        push(mk(60'h0, 16'h0014, 8'd0, 32'h0014_0000, 8'h00), 32'd14);
        chk("bp_ready_full", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_norm;
            wait_out(cyc);
            exp_norm = (i == 2) ? 32'd10 : 32'(10 + i);
            chk("bp_valid", out_valid, 1);
            chk("bp_id", out_boundary_id, 16'h0010 + 16'(i));
            chk("bp_norm", out_norm_value, exp_norm);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("bp_drained", out_valid, 0);
        chk("rec_cnt", rec_count, 12);
        chk("err_cnt", err_count, 5);
        chk("sat_rec_cnt", s_rec_count, 2'b11);
        chk("sat_err_cnt", s_err_count, 2'b11);

        push(mk(60'h0, 16'h0020, 8'd2, 32'h0020_0000, 8'h00), 32'd1000);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rr_valid", out_valid, 0);
        chk("rr_norm", out_norm_value, 0);
        chk("rr_id", out_boundary_id, 0);
        chk("rr_rec_cnt", rec_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rr_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        #1 chk("rr_dropped", out_valid, 0);
        push(mk(60'h0, 16'h0021, 8'd2, 32'h0021_0000, 8'h00), 32'd1003);
        wait_out(cyc);
        chk("rr_latency", cyc, 34);
        chk("rr_next_norm", out_norm_value, 32'd200);
        chk("rr_next_err", out_err, 3'b001);
        consume();
        chk("rr_next_cnt", rec_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
